// File: rtl/reg_file_pkg.sv
// Shared types, defaults and byte-merge helper for the bypassing register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reg_file_pkg;

    localparam int ZERO_REG     = 0;
    localparam int DEF_WIDTH    = 32;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_NUM_READ = 2;

    // Widest data path the merge helper supports; callers zero-extend into it
    // and truncate the result back to their own width.
    localparam int MAX_WIDTH = 128;
    localparam int MAX_BYTES = MAX_WIDTH / 8;

    // Byte-wise select: bytes with be set come from new_v, the rest from old_v.
    // Used identically by the write path and the bypass path so both agree.
    function automatic logic [MAX_WIDTH-1:0] byte_merge(
        input logic [MAX_WIDTH-1:0] old_v,
        input logic [MAX_WIDTH-1:0] new_v,
        input logic [MAX_BYTES-1:0] be
    );
        logic [MAX_WIDTH-1:0] r;
        r = old_v;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared by writeback, set wins on collision.
// Latency: busy visible one cycle after issue; RBusy decode is combinational.
// Backpressure: none; flags feed the hazard unit which decides on stalls.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_READ = DEF_NUM_READ,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   set_i,
    input  logic [AW-1:0]          set_idx_i,
    input  logic                   clr_i,
    input  logic [AW-1:0]          clr_idx_i,
    input  logic [NUM_READ*AW-1:0] rn_i,
    output logic [NUM_READ-1:0]    rbusy_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next busy vector: apply clear first so a same-register set overrides it.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        if (set_i) begin
            busy_d[set_idx_i] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    // Busy state register; reset clears every producer flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A register being written this cycle is forwarded when bypass is on,
    // so it is not reported as a hazard.
    for (genvar k = 0; k < NUM_READ; k++) begin : g_port
        logic [AW-1:0] rn;
        logic          fwd_hit;
        assign rn         = rn_i[k*AW +: AW];
        assign fwd_hit    = (BYPASS != 0) && clr_i && (clr_idx_i == rn);
        assign rbusy_o[k] = !rst_i && busy_q[rn] && !fwd_hit;
    end

endmodule

// File: rtl/reg_file_bypass.sv
// ID-stage register file: byte-enabled write, NUM_READ combinational reads, optional write bypass.
// Latency: reads 0 cycles; writes visible next cycle (same cycle with bypass).
// Backpressure: none; busy flags are exported for load-use stall decisions.
module reg_file_bypass
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_READ = DEF_NUM_READ,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int BW      = WIDTH / 8
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      RegWrite,
    input  logic [AW-1:0]             WN,
    input  logic [WIDTH-1:0]          WD,
    input  logic [BW-1:0]             WBE,
    input  logic [NUM_READ*AW-1:0]    RN,
    output logic [NUM_READ*WIDTH-1:0] RD,
    input  logic                      Issue,
    input  logic [AW-1:0]             IssueWN,
    output logic [NUM_READ-1:0]       RBusy
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] wr_dat_d;
    logic             wr_en;
    logic             issue_en;

    assign wr_en    = RegWrite && (WN != AW'(ZERO_REG));
    assign issue_en = Issue && (IssueWN != AW'(ZERO_REG));
    assign wr_dat_d = WIDTH'(byte_merge(MAX_WIDTH'(regs_q[WN]), MAX_WIDTH'(WD), MAX_BYTES'(WBE)));

    // Storage: merge enabled bytes into the addressed register; register 0 never written.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[WN] <= wr_dat_d;
        end
    end

    // Read ports: stored value, overlaid with same-cycle write bytes on a bypass hit.
    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [AW-1:0]    rn;
        logic             hit;
        logic [WIDTH-1:0] stored;
        logic [WIDTH-1:0] fwd;
        assign rn     = RN[k*AW +: AW];
        assign stored = regs_q[rn];
        assign hit    = (BYPASS != 0) && RegWrite && !Reset && (WN == rn);
        assign fwd    = hit ? WIDTH'(byte_merge(MAX_WIDTH'(stored), MAX_WIDTH'(WD), MAX_BYTES'(WBE)))
                            : stored;
        assign RD[k*WIDTH +: WIDTH] = (Reset || rn == AW'(ZERO_REG)) ? '0 : fwd;
    end

    reg_file_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_READ (NUM_READ),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .set_i     (issue_en),
        .set_idx_i (IssueWN),
        .clr_i     (wr_en),
        .clr_idx_i (WN),
        .rn_i      (RN),
        .rbusy_o   (RBusy)
    );

endmodule

// File: tb/tb_reg_file_bypass.sv
// Bench for reg_file_bypass: a 4-port bypassing instance and a 2-port non-bypassing
// instance share all stimulus and are checked against an array-based reference model.
// Directed test-plan steps first, then randomized traffic with occasional resets.
module tb_reg_file_bypass;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         RegWrite;
    logic [4:0]   WN;
    logic [31:0]  WD;
    logic [3:0]   WBE;
    logic         Issue;
    logic [4:0]   IssueWN;
    logic [4:0]   rn [4];
    logic [19:0]  RN_a;
    logic [9:0]   RN_b;
    logic [127:0] RD_a;
    logic [63:0]  RD_b;
    logic [3:0]   RBusy_a;
    logic [1:0]   RBusy_b;

    assign RN_a = {rn[3], rn[2], rn[1], rn[0]};
    assign RN_b = {rn[1], rn[0]};

    always #5 Clk = ~Clk;

    reg_file_bypass #(.WIDTH(32), .DEPTH(32), .NUM_READ(4), .BYPASS(1)) dut_a (
        .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite), .WN(WN), .WD(WD), .WBE(WBE),
        .RN(RN_a), .RD(RD_a), .Issue(Issue), .IssueWN(IssueWN), .RBusy(RBusy_a)
    );

    reg_file_bypass #(.WIDTH(32), .DEPTH(32), .NUM_READ(2), .BYPASS(0)) dut_b (
        .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite), .WN(WN), .WD(WD), .WBE(WBE),
        .RN(RN_b), .RD(RD_b), .Issue(Issue), .IssueWN(IssueWN), .RBusy(RBusy_b)
    );

    // Reference model: architectural register contents and outstanding-producer flags.
    logic [31:0] m_reg  [32];
    logic        m_busy [32];
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] r);
        logic [31:0] v;
        if (Reset || r == 5'd0) return 32'd0;
        v = m_reg[r];
        if (byp && RegWrite && WN == r) begin
            for (int i = 0; i < 4; i++) if (WBE[i]) v[8*i +: 8] = WD[8*i +: 8];
        end
        return v;
    endfunction

    function automatic logic exp_busy(input bit byp, input logic [4:0] r);
        if (Reset) return 1'b0;
        return m_busy[r] && !(byp && RegWrite && WN == r);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    // State change at a rising edge, from the inputs held across that edge.
    task automatic model_edge();
        if (Reset) begin
            model_clear();
        end else begin
            if (RegWrite && WN != 5'd0) begin
                for (int i = 0; i < 4; i++) if (WBE[i]) m_reg[WN][8*i +: 8] = WD[8*i +: 8];
                m_busy[WN] = 1'b0;
            end
            if (Issue && IssueWN != 5'd0) m_busy[IssueWN] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s a.rd%0d", tag, k), RD_a[k*32 +: 32], exp_rd(1'b1, rn[k]));
            chk($sformatf("%s a.busy%0d", tag, k), 32'(RBusy_a[k]), 32'(exp_busy(1'b1, rn[k])));
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s b.rd%0d", tag, k), RD_b[k*32 +: 32], exp_rd(1'b0, rn[k]));
            chk($sformatf("%s b.busy%0d", tag, k), 32'(RBusy_b[k]), 32'(exp_busy(1'b0, rn[k])));
        end
    endtask

    task automatic idle();
        RegWrite = 1'b0; Issue = 1'b0; WN = 5'd0; WD = 32'd0; WBE = 4'd0; IssueWN = 5'd0;
    endtask

    task automatic write(input logic [4:0] n, input logic [31:0] d, input logic [3:0] be);
        RegWrite = 1'b1; WN = n; WD = d; WBE = be;
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        for (int i = 0; i < 4; i++) rn[i] = 5'd0;
        model_clear();
        tick();

        // Reset then read
        rn[0] = 5'd5; rn[1] = 5'd0;
        #2 check_all("reset");
        chk("reset rd5", RD_a[31:0], 32'd0);
        chk("reset busy", 32'(RBusy_a), 32'd0);
        Reset = 1'b0;
        tick();

        // Write then read; write to register 0 is ignored
        write(5'd1, 32'h12345678, 4'hF);
        #2 check_all("wr1");
        tick();
        idle(); rn[0] = 5'd1;
        #2 check_all("rd1");
        chk("rd1 a", RD_a[31:0], 32'h12345678);
        chk("rd1 b", RD_b[31:0], 32'h12345678);
        write(5'd0, 32'hFFFFFFFF, 4'hF); rn[0] = 5'd0;
        tick();
        idle();
        #2 chk("rd0 a", RD_a[31:0], 32'd0);
        chk("rd0 b", RD_b[31:0], 32'd0);

        // Byte enable plus bypass
        write(5'd3, 32'hAABBCCDD, 4'hF);
        tick();
        write(5'd3, 32'h11223344, 4'b0101); rn[1] = 5'd3;
        #2 check_all("be pre");
        chk("be pre a", RD_a[63:32], 32'hAA22CC44);
        chk("be pre b", RD_b[63:32], 32'hAABBCCDD);
        tick();
        idle();
        #2 check_all("be post");
        chk("be post a", RD_a[63:32], 32'hAA22CC44);
        chk("be post b", RD_b[63:32], 32'hAA22CC44);

        // Scoreboard set, clear by no-op write, and set-wins collision
        Issue = 1'b1; IssueWN = 5'd7; rn[0] = 5'd7;
        #2 chk("issue same cycle", 32'(RBusy_a[0]), 32'd0);
        tick();
        idle();
        #2 chk("busy7 a", 32'(RBusy_a[0]), 32'd1);
        chk("busy7 b", 32'(RBusy_b[0]), 32'd1);
        write(5'd7, 32'h0, 4'h0);
        #2 chk("clr7 a", 32'(RBusy_a[0]), 32'd0);
        chk("clr7 b", 32'(RBusy_b[0]), 32'd1);
        check_all("clr7");
        tick();
        idle();
        #2 chk("clr7 post b", 32'(RBusy_b[0]), 32'd0);
        Issue = 1'b1; IssueWN = 5'd7; write(5'd7, 32'h77, 4'hF);
        tick();
        idle();
        #2 chk("setwins a", 32'(RBusy_a[0]), 32'd1);
        chk("setwins b", 32'(RBusy_b[0]), 32'd1);

        // Async reset mid-operation
        write(5'd2, 32'h0000BEEF, 4'hF); Issue = 1'b1; IssueWN = 5'd9;
        tick();
        idle(); rn[0] = 5'd2; rn[1] = 5'd9;
        #2 chk("pre-rst rd2", RD_a[31:0], 32'h0000BEEF);
        chk("pre-rst busy9", 32'(RBusy_a[1]), 32'd1);
        #1 Reset = 1'b1;
        model_clear();
        #1 chk("async rd2", RD_a[31:0], 32'd0);
        chk("async busy9", 32'(RBusy_a[1]), 32'd0);
        check_all("async");
        write(5'd2, 32'h00001234, 4'hF); Issue = 1'b1; IssueWN = 5'd5;
        tick();
        Reset = 1'b0;
        idle(); rn[2] = 5'd5;
        #2 chk("rst discard rd2", RD_a[31:0], 32'd0);
        chk("rst discard busy5", 32'(RBusy_a[2]), 32'd0);

        // All four ports on a register being written
        write(5'd4, 32'hCAFEF00D, 4'hF);
        tick();
        for (int i = 0; i < 4; i++) rn[i] = 5'd4;
        write(5'd4, 32'h55667788, 4'b0110);
        #2 for (int k = 0; k < 4; k++) chk($sformatf("mp rd%0d", k), RD_a[k*32 +: 32], 32'hCA66770D);
        check_all("mp");
        tick();
        idle();

        // Randomized traffic, biased to low registers so hits and collisions occur
        for (int n = 0; n < 400; n++) begin
            Reset    = ($urandom_range(0, 39) == 0);
            RegWrite = 1'($urandom);
            WN       = 5'($urandom_range(0, 7));
            WD       = $urandom;
            WBE      = 4'($urandom);
            Issue    = 1'($urandom);
            IssueWN  = 5'($urandom_range(0, 7));
            for (int i = 0; i < 4; i++) rn[i] = ($urandom_range(0, 3) == 0) ? WN : 5'($urandom_range(0, 9));
            #2 check_all("rnd");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
